// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller state encodings and the default datapath width.
package mdu_hilo_pkg;

  localparam int MDU_N_DEFAULT = 32;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate. Used as abs() on operand entry and
// as the sign restore on product/quotient/remainder exit.
module mdu_signfix #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);

  assign y = neg ? ({N{1'b0}} - x) : x;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional MTHI/MTLO write ports are enabled with `define MDU_MTHILO_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands latched as magnitudes on start
// RUN     | N iterations: shift-add multiply or restoring divide
// SIGN    | apply sign / divide-by-zero rules, write HI and LO
// DONE    | one-cycle done pulse; start is not accepted here
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int N = MDU_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rd_hi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
`ifdef MDU_MTHILO_EN
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wdata,
`endif
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);

  mdu_state_e     state, state_nxt;
  logic [CW-1:0]  cnt;
  mdu_op_e        op_q;
  logic           sa, sb;
  logic [N-1:0]   mag_a, mag_b;
  logic [2*N-1:0] acc, acc_nxt;
  logic [N-1:0]   abs_a, abs_b, raw_a, quo_fix, rem_fix;
  logic [2*N-1:0] prod_fix;
  logic [N:0]     add_sum, div_shift, div_diff;
  logic           div_ge, last;
  logic           wr_hi, wr_lo;
  logic [N-1:0]   wr_data;

`ifdef MDU_MTHILO_EN
  assign wr_hi   = mthi;
  assign wr_lo   = mtlo;
  assign wr_data = wdata;
`else
  assign wr_hi   = 1'b0;
  assign wr_lo   = 1'b0;
  assign wr_data = {N{1'b0}};
`endif

  assign last   = (cnt == CW'(N - 1));
  assign result = rd_hi ? hi : lo;

  // Signed ops work on magnitudes; sign flags only set for signed ops.
  mdu_signfix #(.N(N)) u_abs_a (.x(a), .neg(op[0] & a[N-1]), .y(abs_a));
  mdu_signfix #(.N(N)) u_abs_b (.x(b), .neg(op[0] & b[N-1]), .y(abs_b));

  // Divide-by-zero returns the dividend as given, so rebuild it from its magnitude.
  mdu_signfix #(.N(N)) u_raw_a (.x(mag_a), .neg(sa), .y(raw_a));

  mdu_signfix #(.N(2*N)) u_prod (.x(acc), .neg(sa ^ sb), .y(prod_fix));
  mdu_signfix #(.N(N)) u_quo  (.x(acc[N-1:0]), .neg(sa ^ sb), .y(quo_fix));
  mdu_signfix #(.N(N)) u_rem  (.x(acc[2*N-1:N]), .neg(sa), .y(rem_fix));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_SIGN;
      end
      ST_SIGN: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One iteration: multiply keeps the multiplier in acc low half and adds
  // into the high half; divide shifts the dividend up into the remainder.
  always_comb begin
    add_sum   = {1'b0, acc[2*N-1:N]} + ({(N+1){acc[0]}} & {1'b0, mag_a});
    div_shift = {acc[2*N-1:N], acc[N-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = (div_shift >= {1'b0, mag_b});
    if (op_q[1])
      acc_nxt = {(div_ge ? div_diff[N-1:0] : div_shift[N-1:0]), acc[N-2:0], div_ge};
    else
      acc_nxt = {add_sum, acc[N-1:1]};
  end

  // Datapath registers; HI/LO only change on SIGN or an idle MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      op_q  <= MDU_MULTU;
      sa    <= 1'b0;
      sb    <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= mdu_op_e'(op);
            sa    <= op[0] & a[N-1];
            sb    <= op[0] & b[N-1];
            mag_a <= abs_a;
            mag_b <= abs_b;
            acc   <= {{N{1'b0}}, (op[1] ? abs_a : abs_b)};
            cnt   <= '0;
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        ST_SIGN: begin
          if (op_q[1]) begin
            if (mag_b == '0) begin
              hi <= raw_a;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU with HI/LO registers.
- `result` is the MFHI/MFLO operand fed into the writeback result 2:1 select, opposite the ALU result.
- Multicycle: the controller stalls on `busy` and resumes on `done`.

Parameters:
- N, 32, operand/HI/LO width (must be ≥2).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  N  multiplicand / dividend (rs)
- b  in  N  multiplier / divisor (rt)
- rd_hi  in  1  1 selects HI onto result, 0 selects LO
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO updated
- hi  out  N  HI register
- lo  out  N  LO register
- result  out  N  rd_hi ? hi : lo, combinational

Behaviour:
- Reset: applied at a clk edge with reset=0. State IDLE, hi=lo=0, busy=0, done=0, counter=0.
- Reset mid-operation aborts the operation; nothing partial is written to HI/LO.
- FSM states: IDLE, RUN, SIGN, DONE.
- IDLE: start=1 at a clock edge latches operands and op.
  - Operands are stored as magnitudes if op is signed (op[0]=1), raw otherwise.
  - Sign flags and op are latched; next state is RUN.
- RUN: N cycles, counter 0..N-1, then SIGN.
  - Multiply: shift-add, one multiplier bit per cycle, 2N-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
- SIGN: one cycle, writes HI/LO, then DONE.
  - Multiply: product negated if signs differ (signed only). hi=upper N, lo=lower N.
  - Divide: lo=quotient, negated if signs differ; hi=remainder, takes the dividend's sign (signed only).
- DONE: done=1 for exactly this cycle, busy=0. Next state IDLE.
  - start is not accepted in DONE; it is accepted on the following cycle.
- Timing, with start high in cycle 0:
  - busy=1 in cycles 1..N+1.
  - done=1 and new hi/lo visible in cycle N+2.
  - Back-to-back issue earliest in cycle N+3.
- start while busy or in DONE: ignored, no queuing.
- op/a/b changes after the start edge: no effect.
- Divide by zero (b=0, any sign): hi=a (raw), lo={N{1}}; sign fix skipped.
- DIV overflow (a=-2^(N-1), b=-1): lo=0x8000_0000, hi=0 for N=32 (natural wrap, no trap).
- All arithmetic is unsigned on magnitudes; negation is two's complement mod 2^N (2^2N for the product).
- result: purely combinational from hi/lo/rd_hi; shows the old HI/LO while busy.

Optional Feature:
- MDU_MTHILO_EN defined adds ports:
  - mthi in 1, mtlo in 1, wdata in N.
- In IDLE, mthi=1 writes wdata to hi at the edge; mtlo=1 writes wdata to lo; both may fire at once.
- No done pulse for these writes.
- If start and mthi/mtlo are high in the same IDLE cycle, start wins and the writes are dropped.
- Writes in RUN/SIGN/DONE are ignored.
- Undefined: the ports do not exist and HI/LO change only via SIGN.

Decomposition:
- Shared package holds:
  - op encodings MDU_MULTU/MDU_MULT/MDU_DIVU/MDU_DIV.
  - FSM state encodings.
  - the default width constant.
- One natural sub-module, mdu_signfix: combinational conditional negate (abs on entry, negate on exit), parameter N.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; rd_hi toggling switches result between them.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU/DIV a=5 b=0 -> hi=5, lo=0xFFFFFFFF. DIV a=0x80000000 b=-1 -> lo=0x80000000, hi=0.
- Second start pulsed in cycle 10 of a MULT -> ignored, one done only. reset=0 in cycle 15 -> busy=0, hi=lo=0, no done, new start accepted next cycle.
- With MDU_MTHILO_EN: mthi wdata=0x12345678 in IDLE -> hi=0x12345678, lo unchanged. mtlo during RUN -> lo unchanged.
